// File: rtl/clk_gate_enable_ctrl.sv
// Clock-gate enable controller: per-domain OFF/WAKE/ON/IDLE FSMs with a parent/child cascade hold.
// All outputs registered from next state (one-cycle latency); no backpressure, req is a held level.
module clk_gate_enable_ctrl #(
    parameter int NUM_DOM     = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = 4,
    parameter int PARENT_DOM  = 2,
    parameter int CHILD_DOM   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_DOM-1:0] req,
    input  logic               force_on,
    output logic [NUM_DOM-1:0] gate_en,
    output logic [NUM_DOM-1:0] ack,
    output logic               busy
);

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_WAKE = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_IDLE = 2'd3;

    localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_DOM-1:0][1:0]       state_q, state_d;
    logic [NUM_DOM-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_DOM-1:0]            gate_en_q, gate_en_d;
    logic [NUM_DOM-1:0]            ack_q, ack_d;
    logic                          busy_q, busy_d;

    logic parent_live;
    logic child_off;

    assign parent_live = (state_q[PARENT_DOM] == S_ON) || (state_q[PARENT_DOM] == S_IDLE);
    assign child_off   = (state_q[CHILD_DOM] == S_OFF);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int d = 0; d < NUM_DOM; d++) begin
            case (state_q[d])
                S_OFF: begin
                    if (req[d] && ((d != CHILD_DOM) || parent_live)) begin
                        state_d[d] = S_WAKE;
                        cnt_d[d]   = WAKE_LD;
                    end
                end
                S_WAKE: begin
                    // Wake always runs to completion so the gated tree settles before any ack.
                    if (cnt_q[d] == '0) begin
                        if (req[d]) begin
                            state_d[d] = S_ON;
                        end else begin
                            state_d[d] = S_IDLE;
                            cnt_d[d]   = IDLE_LD;
                        end
                    end else begin
                        cnt_d[d] = cnt_q[d] - CNT_ONE;
                    end
                end
                S_ON: begin
                    if (!req[d]) begin
                        state_d[d] = S_IDLE;
                        cnt_d[d]   = IDLE_LD;
                    end
                end
                default: begin
                    if (req[d]) begin
                        state_d[d] = S_ON;
                    end else if (cnt_q[d] != '0) begin
                        cnt_d[d] = cnt_q[d] - CNT_ONE;
                    end else if ((d != PARENT_DOM) || child_off) begin
                        // Parent holds at zero while its child's clock still runs off our GCK.
                        state_d[d] = S_OFF;
                    end
                end
            endcase
        end
    end

    always_comb begin
        busy_d = 1'b0;
        for (int d = 0; d < NUM_DOM; d++) begin
            gate_en_d[d] = (state_d[d] != S_OFF) || force_on;
            ack_d[d]     = (state_d[d] == S_ON);
            busy_d       = busy_d || (state_d[d] != S_OFF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= '0;
            cnt_q     <= '0;
            gate_en_q <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gate_en_q <= gate_en_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    assign gate_en = gate_en_q;
    assign ack     = ack_q;
    assign busy    = busy_q;

endmodule

// File: doc/clk_gate_enable_ctrl.md
Name: clk_gate_enable_ctrl

Overview:
- Drives the enable inputs of a bank of CLKGATE_X1 integrated clock gates. It sits on the enable side of the gates that feed DFF_X1 sink groups.
- Converts per-domain level wake requests from sink logic into gate enables, with a wake settle period, a request/ack handshake and an idle-timeout shutdown.
- Supports one cascaded domain pair: a child gate clocked from a parent gate's GCK output.
- Runs on the ungated root clock.

Parameters:
- NUM_DOM, 4, number of gated clock domains.
- WAKE_CYCLES, 2, cycles the enable is high before ack asserts (gate/tree settle); legal range 1..2^CNT_W-1.
- IDLE_CYCLES, 8, cycles with req low before the enable drops; legal range 1..2^CNT_W-1.
- CNT_W, 4, per-domain counter width.
- PARENT_DOM, 2, index of the parent domain in the cascade.
- CHILD_DOM, 1, index of the child domain (gate clocked by the parent's GCK); must differ from PARENT_DOM.

Ports:
- clk, input, 1, root clock (ungated).
- rst_n, input, 1, asynchronous active-low reset.
- req, input, NUM_DOM, per-domain level wake request; held high while the domain needs its clock.
- force_on, input, 1, scan/test override; all gate_en high while asserted.
- gate_en, output, NUM_DOM, registered enable to each CLKGATE_X1.
- ack, output, NUM_DOM, registered; high means the domain's gated clock is running and stable.
- busy, output, 1, registered OR of all domains not in OFF.

Behaviour:
- Reset (rst_n low, asynchronous): all domains go to OFF, gate_en=0, ack=0, busy=0, counters=0. Reset mid-WAKE or mid-IDLE aborts the domain to OFF immediately.
- Each domain has an independent FSM with states OFF, WAKE, ON, IDLE. All outputs are registered and derived from the next state.
- OFF: gate_en=0, ack=0.
  - If req=1 and the domain is eligible, go to WAKE and load cnt=WAKE_CYCLES-1.
  - The child domain is eligible only when the parent is in ON or IDLE. Otherwise it stays OFF until that holds.
  - The parent becomes eligible whenever its own req=1.
- WAKE: gate_en=1, ack=0, cnt decrements.
  - When cnt==0, go to ON.
  - If req drops during WAKE, still complete WAKE, then go to IDLE (no ack pulse).
  - Result: req rising at edge N gives gate_en=1 at N+1 and ack=1 at N+1+WAKE_CYCLES.
- ON: gate_en=1, ack=1.
  - If req=0, go to IDLE, load cnt=IDLE_CYCLES-1, and drop ack in that same cycle.
- IDLE: gate_en=1, ack=0, cnt decrements.
  - If req=1, return to ON with ack=1 on the next edge; no wake delay, because the clock never stopped.
  - If cnt==0 and req=0, go to OFF.
- Cascade rule: the parent may not leave IDLE for OFF while the child is not in OFF. At cnt==0 the parent holds cnt at 0 and stays in IDLE until the child reaches OFF.
- Child request without parent request: the child's req does not implicitly wake the parent. The child waits in OFF; software and sink logic must request both.
- Parent leaving ON/IDLE (only possible via the hold rule above): the child is always already OFF at that point, so no forced child shutdown exists.
- force_on:
  - gate_en is all ones combinationally ORed at the register input, so it takes effect one cycle later.
  - FSMs and ack continue to operate normally.
  - Deasserting force_on returns gate_en to the FSM value on the next edge.
- Simultaneous events:
  - A req toggle on the same edge as a counter expiry resolves by the state rules above. req is sampled first in IDLE; an expiry in WAKE completes regardless of req.
  - Counters never wrap; they saturate at 0.
- busy = OR over domains of (state != OFF), registered.

Test Plan:
- Reset/idle: rst_n low for 3 cycles with req=4'b1111 -> gate_en=0, ack=0, busy=0 throughout; after release, domain 0 gate_en=1 at +1 and ack=1 at +3 (WAKE_CYCLES=2).
- Idle timeout: req[0] high for 10 cycles then low -> ack[0] drops on the next edge, gate_en[0] stays high 8 more cycles, then 0. Re-raising req at idle cycle 5 -> ack=1 next edge with no wake delay.
- Cascade: req[1]=1 with req[2]=0 -> gate_en[1] stays 0 indefinitely. Raise req[2] -> gate_en[2] at +1, ack[2] at +3, gate_en[1] at +4, ack[1] at +6. Drop req[2] first -> gate_en[2] stays high until domain 1 reaches OFF.
- Reset mid-operation: assert rst_n low during domain 3 WAKE (cnt=1) -> gate_en[3] and busy go to 0 asynchronously, before the next clk edge.
- force_on: assert with all req=0 -> gate_en=4'b1111 one cycle later, ack=0, busy=0; deassert -> gate_en=0 next edge.
- req pulse of 1 cycle -> domain completes WAKE (gate_en high 2 cycles), ack never asserts, then IDLE for 8 cycles, then OFF.
